// File: rtl/seg_scan_ctrl_if.sv
// Frame-load handshake and display bus of the seven-segment scan controller.
// The requester side drives the frame; the controller drives the panel lines.
interface seg_scan_ctrl_if;
    logic [31:0] data_i;
    logic [7:0]  en_i;
    logic [7:0]  dp_i;
    logic        load_i;
    logic        load_ack_o;
    logic        frame_o;
    logic [7:0]  AN;
    logic [6:0]  C;
    logic        DP;

    modport master (
        output data_i, en_i, dp_i, load_i,
        input  load_ack_o, frame_o, AN, C, DP
    );

    modport slave (
        input  data_i, en_i, dp_i, load_i,
        output load_ack_o, frame_o, AN, C, DP
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed driver for an 8-digit common-anode seven-segment display.
// New frame content is taken only at a frame boundary so a shown frame never tears.
module seg_scan_ctrl #(
    parameter int DIGIT_TICKS = 100000,
    parameter int BLANK_TICKS = 1000
) (
    input  logic          clk,
    input  logic          rst_n,
    seg_scan_ctrl_if.slave bus
);
    localparam int MAX_TICKS = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
    localparam int CW        = $clog2(MAX_TICKS + 1);
    localparam logic [CW-1:0] D_LAST = CW'(DIGIT_TICKS - 1);
    localparam logic [CW-1:0] B_LAST = CW'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);

    typedef enum logic {
        BLANK,
        SHOW
    } state_t;

    state_t        state;
    logic [2:0]    idx;
    logic [CW-1:0] cnt;
    logic [31:0]   shadow_data;
    logic [7:0]    shadow_en;
    logic [7:0]    shadow_dp;

    logic       show_end;
    logic       blank_end;
    logic       boundary;
    logic [3:0] nibble;

    assign show_end  = (state == SHOW) && (cnt == D_LAST);
    assign blank_end = (state == BLANK) && ((BLANK_TICKS == 0) || (cnt == B_LAST));
    assign boundary  = show_end && (idx == 3'd7);
    assign nibble    = shadow_data[{idx, 2'b00} +: 4];

    // Segment order {g,f,e,d,c,b,a}, active-low.
    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        case (v)
            4'h0:    hex_seg = 7'b1000000;
            4'h1:    hex_seg = 7'b1111001;
            4'h2:    hex_seg = 7'b0100100;
            4'h3:    hex_seg = 7'b0110000;
            4'h4:    hex_seg = 7'b0011001;
            4'h5:    hex_seg = 7'b0010010;
            4'h6:    hex_seg = 7'b0000010;
            4'h7:    hex_seg = 7'b1111000;
            4'h8:    hex_seg = 7'b0000000;
            4'h9:    hex_seg = 7'b0010000;
            4'hA:    hex_seg = 7'b0001000;
            4'hB:    hex_seg = 7'b0000011;
            4'hC:    hex_seg = 7'b1000110;
            4'hD:    hex_seg = 7'b0100001;
            4'hE:    hex_seg = 7'b0000110;
            default: hex_seg = 7'b0001110;
        endcase
    endfunction

    // NOTE: every register below uses <= so all of them see the same pre-edge
    // values of state/idx/cnt; blocking here would let later lines see new state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= BLANK;
            idx            <= 3'd0;
            cnt            <= '0;
            shadow_data    <= '0;
            shadow_en      <= '0;
            shadow_dp      <= '0;
            bus.AN         <= 8'hFF;
            bus.C          <= 7'h7F;
            bus.DP         <= 1'b1;
            bus.load_ack_o <= 1'b0;
            bus.frame_o    <= 1'b0;
        end else begin
            bus.frame_o    <= boundary;
            bus.load_ack_o <= boundary && bus.load_i;

            if (boundary && bus.load_i) begin
                shadow_data <= bus.data_i;
                shadow_en   <= bus.en_i;
                shadow_dp   <= bus.dp_i;
            end

            if (show_end) begin
                idx   <= idx + 3'd1;
                state <= (BLANK_TICKS == 0) ? SHOW : BLANK;
                cnt   <= '0;
            end else if (blank_end) begin
                state <= SHOW;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end

            // Disabled digits stay dark but keep their slot, so frame timing is fixed.
            if ((state == SHOW) && shadow_en[idx]) begin
                bus.AN <= ~(8'h01 << idx);
                bus.C  <= hex_seg(nibble);
                bus.DP <= ~shadow_dp[idx];
            end else begin
                bus.AN <= 8'hFF;
                bus.C  <= 7'h7F;
                bus.DP <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl: every cycle's panel and pulse outputs are
// compared with a slot-arithmetic model of the frame schedule.
module tb_seg_scan_ctrl;
    localparam int B     = 2;
    localparam int D     = 4;
    localparam int SLOT  = B + D;
    localparam int FRAME = 8 * SLOT;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    seg_scan_ctrl_if bus ();

    seg_scan_ctrl #(.DIGIT_TICKS(D), .BLANK_TICKS(B)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Shadow content valid in the current and the previous cycle.
    logic [31:0] sh_data, prev_data;
    logic [7:0]  sh_en, prev_en, sh_dp, prev_dp;
    logic        prev_load;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Sample mid-cycle; outputs in cycle n reflect the schedule position of cycle n-1.
    always @(negedge clk) begin
        int m, p, slot, w;
        logic [7:0] exp_an;
        logic [6:0] exp_c;
        logic       exp_dp, exp_frame;
        if (!rst_n) begin
            check("rst_an", 32'(bus.AN), 32'hFF);
            check("rst_c", 32'(bus.C), 32'h7F);
            check("rst_dp", 32'(bus.DP), 32'h1);
            check("rst_ack", 32'(bus.load_ack_o), 32'h0);
            check("rst_frame", 32'(bus.frame_o), 32'h0);
            sh_data = '0; sh_en = '0; sh_dp = '0;
            prev_data = '0; prev_en = '0; prev_dp = '0;
            prev_load = 1'b0;
            cyc = 1;
        end else begin
            cyc++;
            m    = cyc - 1;
            p    = (m - 1) % FRAME;
            slot = p / SLOT;
            w    = p % SLOT;
            exp_an = 8'hFF;
            exp_c  = 7'h7F;
            exp_dp = 1'b1;
            if (w >= B && prev_en[slot]) begin
                exp_an[slot] = 1'b0;
                exp_c        = SEG_TAB[prev_data[slot*4 +: 4]];
                exp_dp       = ~prev_dp[slot];
            end
            exp_frame = (m % FRAME == 0);
            check("an", 32'(bus.AN), 32'(exp_an));
            check("c", 32'(bus.C), 32'(exp_c));
            check("dp", 32'(bus.DP), 32'(exp_dp));
            check("frame", 32'(bus.frame_o), 32'(exp_frame));
            check("ack", 32'(bus.load_ack_o), 32'(exp_frame && prev_load));
            prev_data = sh_data; prev_en = sh_en; prev_dp = sh_dp;
            prev_load = bus.load_i;
            if (cyc % FRAME == 0 && bus.load_i) begin
                sh_data = bus.data_i; sh_en = bus.en_i; sh_dp = bus.dp_i;
            end
        end
    end

    // Advance to just after the next rising edge; the current cycle is then cyc+1.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_to_phase(input int ph);
        do step(); while (((cyc + 1) % FRAME) != ph);
    endtask

    task automatic idle(input int n, input bit jitter);
        for (int i = 0; i < n; i++) begin
            step();
            if (jitter) begin
                bus.data_i = $urandom;
                bus.en_i   = 8'($urandom);
                bus.dp_i   = 8'($urandom);
            end
        end
    endtask

    task automatic do_load(input logic [31:0] d, input logic [7:0] e, input logic [7:0] p);
        bit got_ack = 1'b0;
        bus.data_i = d;
        bus.en_i   = e;
        bus.dp_i   = p;
        bus.load_i = 1'b1;
        for (int i = 0; i < 2 * FRAME && !got_ack; i++) begin
            step();
            got_ack = bus.load_ack_o;
        end
        if (!got_ack) check("ack_timeout", 32'h0, 32'h1);
        step();
        bus.load_i = 1'b0;
    endtask

    task automatic withdrawn_request(input int up, input int down);
        step_to_phase(up);
        bus.load_i = 1'b1;
        step_to_phase(down);
        bus.load_i = 1'b0;
    endtask

    initial begin
        bus.data_i = '0;
        bus.en_i   = '0;
        bus.dp_i   = '0;
        bus.load_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Dark display and bare frame pulses with no load.
        idle(100, 1'b1);

        // First load, request raised at cycle 5 of a frame.
        step_to_phase(5);
        do_load(32'h76543210, 8'hFF, 8'h01);
        idle(2 * FRAME, 1'b1);

        do_load(32'hFEDCBA98, 8'hFF, 8'h00);
        idle(FRAME, 1'b1);

        do_load(32'h13579BDF, 8'h0F, 8'hA5);
        idle(2 * FRAME, 1'b1);

        withdrawn_request(10, 30);
        idle(FRAME, 1'b0);

        for (int k = 0; k < 6; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                int up = $urandom_range(1, 20);
                withdrawn_request(up, up + $urandom_range(1, 25));
            end else begin
                step_to_phase($urandom_range(1, FRAME - 1));
                do_load($urandom, 8'($urandom), 8'($urandom));
            end
            idle($urandom_range(10, FRAME + 10), 1'b1);
        end

        // Reset in the middle of digit 3's lit slot, with all digits enabled.
        do_load(32'h89ABCDEF, 8'hFF, 8'hFF);
        step_to_phase(3 * SLOT + B + 2);
        #1 rst_n = 1'b0;
        #1;
        check("async_an", 32'(bus.AN), 32'hFF);
        check("async_c", 32'(bus.C), 32'h7F);
        check("async_dp", 32'(bus.DP), 32'h1);
        bus.load_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        bus.load_i = 1'b0;
        idle(FRAME + 20, 1'b1);

        do_load($urandom, 8'($urandom), 8'($urandom));
        idle(FRAME + 5, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexing controller for the board's 8-digit, common-anode seven-segment display. It holds a frame of eight hex nibbles, a per-digit enable mask and a per-digit decimal-point mask, then cycles one digit at a time onto the shared segment bus (`C`, `DP`) while driving the matching anode line (`AN`). A blanking gap between digits prevents ghosting. New frame content is accepted through a request/acknowledge handshake, and only at a frame boundary, so a displayed frame never tears.

## Interface
- `DIGIT_TICKS`, default 100000: cycles each digit is lit; must be ≥1 (1 ms at 100 MHz).
- `BLANK_TICKS`, default 1000: cycles all anodes are off before each digit; 0 means no blanking slot.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `data_i`  in  32  eight nibbles; digit k = `data_i[4k+3:4k]`.
- `en_i`  in  8  digit k is lit only if `en_i[k]`=1.
- `dp_i`  in  8  decimal point k is lit if `dp_i[k]`=1.
- `load_i`  in  1  level request to capture `data_i`/`en_i`/`dp_i`.
- `load_ack_o`  out  1  one-cycle pulse: capture done.
- `frame_o`  out  1  one-cycle pulse at each frame boundary.
- `AN`  out  8  anodes, active-low, one-hot-low or all-high.
- `C`  out  7  segments {g,f,e,d,c,b,a}, so `C[0]`=a; active-low.
- `DP`  out  1  decimal point, active-low.

## Operation
- Shadow registers hold data (32 bits), en (8) and dp (8). The display is driven only from the shadow registers.
- FSM states and transitions:
  - BLANK: stay for BLANK_TICKS cycles, then go to SHOW. If BLANK_TICKS=0, SHOW follows SHOW directly.
  - SHOW: stay for DIGIT_TICKS cycles. Then increment `idx` (3 bits, 7 wraps to 0) and go to BLANK.
- Tick counter: `$clog2(max(DIGIT_TICKS,BLANK_TICKS)+1)` bits. It clears on every state change.
- Frame boundary is the cycle in which SHOW of idx 7 ends.
  - `frame_o` pulses.
  - If `load_i`=1 in that cycle, the shadow registers capture the inputs and `load_ack_o` pulses.
- Handshake rules:
  - The requester holds `load_i` and the inputs stable until it sees `load_ack_o`, then drops `load_i` the next cycle.
  - If `load_i` is withdrawn before the boundary, nothing is captured and there is no ack.
  - Inputs are sampled only at the boundary; changes at any other time are ignored.
- Output decode:
  - In SHOW with shadow en[idx]=1: `AN` = ~(1<<idx), `C` = hex segment code of nibble idx, `DP` = ~dp[idx].
  - In all other cases (BLANK, or digit disabled): `AN`=8'hFF, `C`=7'h7F, `DP`=1.
  - A disabled digit still uses its full slot, so frame timing is fixed.
- Hex codes for `C`:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110

## Timing
- Reset state (asynchronous, immediate):
  - FSM=BLANK, idx=0, counter=0, shadow regs=0.
  - Outputs: `AN`=8'hFF, `C`=7'h7F, `DP`=1, `load_ack_o`=0, `frame_o`=0.
  - Because shadow en=0 after reset, the display stays dark until the first load.
- Frame period: 8×(BLANK_TICKS+DIGIT_TICKS) cycles. The first boundary falls at cycle 8×(B+D) after reset release, counting the first edge as cycle 1.
- `AN`/`C`/`DP` are registered and lag the FSM state by one cycle. Each digit is lit for exactly DIGIT_TICKS cycles.
- The new shadow contents are first shown in digit 0 of the following frame.
- `load_ack_o` and `frame_o` are registered and rise the cycle after the boundary cycle.
- Reset asserted mid-SHOW or mid-load: all state returns to reset values immediately; a pending request is lost and gets no ack.

## Test plan
All scenarios use BLANK_TICKS=2, DIGIT_TICKS=4 (48-cycle frame).
- Reset, no load, run 100 cycles -> `AN`=FF, `C`=7F, `DP`=1 throughout; `frame_o` pulses at cycles 49 and 97; `load_ack_o`=0.
- `data_i`=32'h76543210, `en_i`=FF, `dp_i`=01, `load_i` high from cycle 5 -> `load_ack_o` at cycle 49. Digit 0 then shows `AN`=FE, `C`=1000000, `DP`=0 for 4 cycles, then `AN`=FF for 2 cycles. Digit 1 then shows `AN`=FD, `C`=1111001, `DP`=1. All eight digits appear in order, and the sequence wraps.
- `data_i`=32'hFEDCBA98, `en_i`=FF loaded -> digit 0 `C`=0000000, digit 2 `C`=0001000, digit 7 `C`=0001110.
- `en_i`=0F loaded -> digits 4–7 keep `AN`=FF for their 6-cycle slots; digits 0–3 unchanged; `frame_o` spacing stays 48.
- `load_i` raised at cycle 10, dropped at cycle 30 -> no `load_ack_o`; displayed content unchanged over the next frame.
- `rst_n` pulsed low during the SHOW slot of digit 3 -> same cycle `AN`=FF, `C`=7F; after release the display stays dark until a new load is acknowledged.
